pipeline_ctrl: RTL and testbench

Pipeline sequencing controller for the arriskv core; sits beside the instruction decode stage and decides each cycle whether the decoded instruction issues to execute, stalls, or is flushed. It keeps a per-register scoreboard of outstanding load destinations and stalls load-use and WAW-on-load hazards. It bounds in-flight loads and inserts a fixed flush window after a taken jump/branch redirect from execute.

---
 rtl/arriskv_pkg.sv | 13 +
 rtl/reg_scoreboard.sv | 54 +++++
 rtl/pipeline_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/arriskv_pkg.sv
// Shared types for the arriskv pipeline control slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package arriskv_pkg;

  // Sequencing controller state. A hazard stall is a combinational
  // condition inside RUN, not a separate state.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for outstanding load destinations.
// Latency: set/clear take effect on the next clock edge; lookups read registered bits.
// Backpressure: none; the owner decides when to set or clear.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   set_en, set_addr       mark a register pending (x0 is ignored)
//   clr_en, clr_addr       release a register (set wins on a same-cycle collision)
//   rs1_addr/rs2_addr/rd_addr -> rs1_pending/rs2_pending/rd_pending lookups
module reg_scoreboard #(
  parameter int  n_regs_p  = 32,
  localparam int wd_addr_p = $clog2(n_regs_p)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [wd_addr_p-1:0] set_addr,
  input  logic                 clr_en,
  input  logic [wd_addr_p-1:0] clr_addr,
  input  logic [wd_addr_p-1:0] rs1_addr,
  input  logic [wd_addr_p-1:0] rs2_addr,
  input  logic [wd_addr_p-1:0] rd_addr,
  output logic                 rs1_pending,
  output logic                 rs2_pending,
  output logic                 rd_pending
);

  logic [n_regs_p-1:0] pending;
  logic [n_regs_p-1:0] set_mask;
  logic [n_regs_p-1:0] clr_mask;
  logic [n_regs_p-1:0] pending_nxt;

  // x0 is hardwired zero, so it can never become pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_addr != '0)) set_mask[set_addr] = 1'b1;
    if (clr_en)                     clr_mask[clr_addr] = 1'b1;
  end

  // Set is applied after clear so a new load to the same register
  // survives the completion of the older one.
  assign pending_nxt = (pending & ~clr_mask) | set_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign rs1_pending = pending[rs1_addr];
  assign rs2_pending = pending[rs2_addr];
  assign rd_pending  = pending[rd_addr];

endmodule

// File: rtl/pipeline_ctrl.sv
// Decode-stage sequencing: issue / stall / flush decision with load scoreboard.
// Latency: issue, stall and flush are combinational in the current cycle; state moves on the next edge.
// Backpressure: o_stall holds fetch/decode on load-use, WAW-on-load or in-flight load limit.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_dec_*                         decoded instruction (valid, sources, dest, load flag)
//   i_ex_redirect                   taken jump/branch from execute, starts the flush window
//   i_ld_done, i_ld_rdest           load writeback releasing its destination
//   o_issue, o_stall, o_flush       per-cycle decision
//   o_loads_inflight                loads issued and not yet completed
module pipeline_ctrl
  import arriskv_pkg::*;
#(
  parameter int  n_regs_p       = 32,
  parameter int  max_loads_p    = 2,
  parameter int  flush_cycles_p = 2,
  localparam int wd_addr_p      = $clog2(n_regs_p)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_dec_valid,
  input  logic [wd_addr_p-1:0] i_dec_rs1,
  input  logic [wd_addr_p-1:0] i_dec_rs2,
  input  logic                 i_dec_use_rs1,
  input  logic                 i_dec_use_rs2,
  input  logic [wd_addr_p-1:0] i_dec_rdest,
  input  logic                 i_dec_load,
  input  logic                 i_ex_redirect,
  input  logic                 i_ld_done,
  input  logic [wd_addr_p-1:0] i_ld_rdest,
  output logic                 o_issue,
  output logic                 o_stall,
  output logic                 o_flush,
  output logic [2:0]           o_loads_inflight
);

  localparam int               fc_w         = (flush_cycles_p > 1) ? $clog2(flush_cycles_p) : 1;
  localparam logic [fc_w-1:0]  flush_load_c = fc_w'(flush_cycles_p - 1);
  localparam logic [2:0]       max_loads_c  = 3'(max_loads_p);

  ctrl_state_t     state, state_nxt;
  logic [fc_w-1:0] flush_cnt, flush_cnt_nxt;
  logic [2:0]      ld_cnt;

  logic rs1_pending, rs2_pending, rd_pending;
  logic hazard;
  logic ld_issue;
  logic ld_retire;

  reg_scoreboard #(
    .n_regs_p (n_regs_p)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en      (ld_issue),
    .set_addr    (i_dec_rdest),
    .clr_en      (i_ld_done),
    .clr_addr    (i_ld_rdest),
    .rs1_addr    (i_dec_rs1),
    .rs2_addr    (i_dec_rs2),
    .rd_addr     (i_dec_rdest),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .rd_pending  (rd_pending)
  );

  // Lookups see registered pending bits, so a completing load only
  // releases a dependent on the following cycle.
  assign hazard = i_dec_valid &
                  ((i_dec_use_rs1 & rs1_pending) |
                   (i_dec_use_rs2 & rs2_pending) |
                   (i_dec_load & rd_pending) |
                   (i_dec_load & (ld_cnt == max_loads_c)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // A redirect outranks any hazard: it kills decode this cycle and
  // (re)starts the flush window.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    o_flush       = i_ex_redirect;
    o_issue       = 1'b0;
    o_stall       = 1'b0;
    case (state)
      RUN: begin
        if (i_ex_redirect) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = flush_load_c;
        end else begin
          o_issue = i_dec_valid & ~hazard;
          o_stall = hazard;
        end
      end
      FLUSH: begin
        o_flush = 1'b1;
        if (i_ex_redirect) begin
          flush_cnt_nxt = flush_load_c;
        end else if (flush_cnt == '0) begin
          state_nxt = RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt     = RUN;
        flush_cnt_nxt = '0;
      end
    endcase
  end

  assign ld_issue  = o_issue & i_dec_load;
  // A completion with nothing counted is dropped so the count never wraps.
  assign ld_retire = i_ld_done & (ld_cnt != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt <= 3'd0;
    end else begin
      case ({ld_issue, ld_retire})
        2'b10:   ld_cnt <= ld_cnt + 3'd1;
        2'b01:   ld_cnt <= ld_cnt - 3'd1;
        default: ld_cnt <= ld_cnt;
      endcase
    end
  end

  assign o_loads_inflight = ld_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: each driven cycle queues its expected
// outputs, a negedge monitor pops and compares them against the DUT.
// Flush window is flush_cycles_p+1 cycles; load limit is 2.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_dec_valid;
  logic [4:0] i_dec_rs1, i_dec_rs2, i_dec_rdest, i_ld_rdest;
  logic       i_dec_use_rs1, i_dec_use_rs2, i_dec_load;
  logic       i_ex_redirect, i_ld_done;
  logic       o_issue, o_stall, o_flush;
  logic [2:0] o_loads_inflight;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    bit    issue;
    bit    stall;
    bit    flush;
    int    cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .n_regs_p       (32),
    .max_loads_p    (2),
    .flush_cycles_p (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_dec_valid      (i_dec_valid),
    .i_dec_rs1        (i_dec_rs1),
    .i_dec_rs2        (i_dec_rs2),
    .i_dec_use_rs1    (i_dec_use_rs1),
    .i_dec_use_rs2    (i_dec_use_rs2),
    .i_dec_rdest      (i_dec_rdest),
    .i_dec_load       (i_dec_load),
    .i_ex_redirect    (i_ex_redirect),
    .i_ld_done        (i_ld_done),
    .i_ld_rdest       (i_ld_rdest),
    .o_issue          (o_issue),
    .o_stall          (o_stall),
    .o_flush          (o_flush),
    .o_loads_inflight (o_loads_inflight)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are combinational from inputs driven #1 after posedge, so the
  // negedge of the same cycle sees this cycle's decision.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq({e.tag, ".issue"}, int'(o_issue), int'(e.issue));
      check_eq({e.tag, ".stall"}, int'(o_stall), int'(e.stall));
      check_eq({e.tag, ".flush"}, int'(o_flush), int'(e.flush));
      check_eq({e.tag, ".count"}, int'(o_loads_inflight), e.cnt);
    end
  end

  // One cycle of stimulus plus its expected outputs.
  task automatic cyc(input string tag, input bit rst,
                     input bit v, input bit ld, input int rd,
                     input int r1, input bit u1, input int r2, input bit u2,
                     input bit redir, input bit done, input int drd,
                     input bit e_is, input bit e_st, input bit e_fl, input int e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = rst;
    i_dec_valid   = v;
    i_dec_load    = ld;
    i_dec_rdest   = 5'(rd);
    i_dec_rs1     = 5'(r1);
    i_dec_use_rs1 = u1;
    i_dec_rs2     = 5'(r2);
    i_dec_use_rs2 = u2;
    i_ex_redirect = redir;
    i_ld_done     = done;
    i_ld_rdest    = 5'(drd);
    e.tag   = tag;
    e.issue = e_is;
    e.stall = e_st;
    e.flush = e_fl;
    e.cnt   = e_cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    i_dec_valid = 0; i_dec_load = 0; i_dec_rdest = 0;
    i_dec_rs1 = 0; i_dec_use_rs1 = 0; i_dec_rs2 = 0; i_dec_use_rs2 = 0;
    i_ex_redirect = 0; i_ld_done = 0; i_ld_rdest = 0;

    //   tag        rst v ld rd r1 u1 r2 u2 rdr dn drd   is st fl cnt
    cyc("reset0",    0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
    cyc("reset1",    0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
    cyc("idle",      1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);

    // Load-use on x5
    cyc("lu_lw5",    1, 1, 1, 5, 1, 1, 0, 0, 0,  0, 0,   1, 0, 0, 0);
    cyc("lu_add_s0", 1, 1, 0, 6, 5, 1, 1, 1, 0,  0, 0,   0, 1, 0, 1);
    cyc("lu_add_s1", 1, 1, 0, 6, 5, 1, 1, 1, 0,  0, 0,   0, 1, 0, 1);
    cyc("lu_add_dn", 1, 1, 0, 6, 5, 1, 1, 1, 0,  1, 5,   0, 1, 0, 1);
    cyc("lu_add_is", 1, 1, 0, 6, 5, 1, 1, 1, 0,  0, 0,   1, 0, 0, 0);
    cyc("lu_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);

    // Single redirect: flush t..t+2, then issue resumes
    cyc("rd_t0",     1, 1, 0, 1, 2, 1, 3, 1, 1,  0, 0,   0, 0, 1, 0);
    cyc("rd_t1",     1, 1, 0, 1, 2, 1, 3, 1, 0,  0, 0,   0, 0, 1, 0);
    cyc("rd_t2",     1, 1, 0, 1, 2, 1, 3, 1, 0,  0, 0,   0, 0, 1, 0);
    cyc("rd_t3",     1, 1, 0, 1, 2, 1, 3, 1, 0,  0, 0,   1, 0, 0, 0);
    // Back-to-back redirect extends to t+3
    cyc("rr_t0",     1, 1, 0, 1, 2, 1, 3, 1, 1,  0, 0,   0, 0, 1, 0);
    cyc("rr_t1",     1, 1, 0, 1, 2, 1, 3, 1, 1,  0, 0,   0, 0, 1, 0);
    cyc("rr_t2",     1, 1, 0, 1, 2, 1, 3, 1, 0,  0, 0,   0, 0, 1, 0);
    cyc("rr_t3",     1, 1, 0, 1, 2, 1, 3, 1, 0,  0, 0,   0, 0, 1, 0);
    cyc("rr_t4",     1, 1, 0, 1, 2, 1, 3, 1, 0,  0, 0,   1, 0, 0, 0);

    // In-flight load limit
    cyc("lim_lw7",   1, 1, 1, 7, 1, 1, 0, 0, 0,  0, 0,   1, 0, 0, 0);
    cyc("lim_lw8",   1, 1, 1, 8, 1, 1, 0, 0, 0,  0, 0,   1, 0, 0, 1);
    cyc("lim_lw9s",  1, 1, 1, 9, 1, 1, 0, 0, 0,  0, 0,   0, 1, 0, 2);
    cyc("lim_lw9d",  1, 1, 1, 9, 1, 1, 0, 0, 0,  1, 7,   0, 1, 0, 2);
    cyc("lim_lw9i",  1, 1, 1, 9, 1, 1, 0, 0, 0,  0, 0,   1, 0, 0, 1);
    cyc("lim_dn8",   1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 8,   0, 0, 0, 2);
    cyc("lim_dn9",   1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 9,   0, 0, 0, 1);
    cyc("sat_dn0",   1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 3,   0, 0, 0, 0);
    cyc("sat_chk",   1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);

    // x0 destination never pending, x0 reads never stall
    cyc("x0_lw",     1, 1, 1, 0, 1, 1, 0, 0, 0,  0, 0,   1, 0, 0, 0);
    cyc("x0_add",    1, 1, 0, 1, 0, 1, 0, 1, 0,  0, 0,   1, 0, 0, 1);
    cyc("x0_lw2",    1, 1, 1, 0, 2, 1, 0, 0, 0,  0, 0,   1, 0, 0, 1);
    cyc("x0_dn_a",   1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,   0, 0, 0, 2);
    cyc("x0_dn_b",   1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,   0, 0, 0, 1);
    cyc("x0_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);

    // Same-cycle set and clear of x4: set wins, count unchanged
    cyc("sc_lw3",    1, 1, 1, 3, 1, 1, 0, 0, 0,  0, 0,   1, 0, 0, 0);
    cyc("sc_lw4dn",  1, 1, 1, 4, 1, 1, 0, 0, 0,  1, 4,   1, 0, 0, 1);
    cyc("sc_use4",   1, 1, 0, 5, 4, 1, 0, 0, 0,  0, 0,   0, 1, 0, 1);
    cyc("sc_waw4",   1, 1, 1, 4, 1, 1, 0, 0, 0,  0, 0,   0, 1, 0, 1);
    cyc("sc_use4dn", 1, 1, 0, 5, 4, 1, 0, 0, 0,  1, 4,   0, 1, 0, 1);
    cyc("sc_use4is", 1, 1, 0, 5, 4, 1, 0, 0, 0,  0, 0,   1, 0, 0, 0);
    // Redirect overrides a pending hazard on x3
    cyc("pri_rdr",   1, 1, 0, 5, 3, 1, 0, 0, 1,  0, 0,   0, 0, 1, 0);
    cyc("pri_f1",    1, 1, 0, 5, 3, 1, 0, 0, 0,  0, 0,   0, 0, 1, 0);
    cyc("pri_f2",    1, 1, 0, 5, 3, 1, 0, 0, 0,  0, 0,   0, 0, 1, 0);
    cyc("pri_stall", 1, 1, 0, 5, 3, 1, 0, 0, 0,  0, 0,   0, 1, 0, 0);

    // Reset during FLUSH with two loads in flight
    cyc("rs_lw10",   1, 1, 1, 10, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    cyc("rs_lw11",   1, 1, 1, 11, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 1);
    cyc("rs_rdr",    1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0,   0, 0, 1, 2);
    cyc("rs_fl",     1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 1, 2);
    cyc("rs_assert", 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
    cyc("rs_use",    1, 1, 0, 1, 3, 1, 10, 1, 0, 0, 0,   1, 0, 0, 0);
    cyc("rs_lw11b",  1, 1, 1, 11, 11, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    cyc("rs_end",    1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 1);

    repeat (3) @(posedge clk);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
